// File: rtl/sl_sram_bist_if.sv
// SRAM access port between a March BIST initiator and one sl_sram bank.
interface sl_sram_bist_if #(
    parameter int unsigned AW = 14
);
    logic          cs;
    logic [AW-3:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wren;
    logic [31:0]   rdata;

    modport master (output cs, addr, wdata, wren, input rdata);
    modport slave  (input cs, addr, wdata, wren, output rdata);
endinterface

// File: rtl/sl_sram_bist.sv
// March C- self-test initiator for one word-wide sl_sram bank.
// Reports pass/fail plus the word address and element of the first miscompare.
module sl_sram_bist #(
    parameter int unsigned AW    = 14,
    parameter logic [31:0] DATA0 = 32'h0000_0000
) (
    input  logic           hclk,
    input  logic           hresetn,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           fail,
    output logic [AW-3:0]  fail_addr,
    output logic [2:0]     fail_elem,
    sl_sram_bist_if.master sram
);
    localparam int unsigned WAW = AW - 2;
    localparam logic [WAW-1:0] ADDR_ZERO = '0;
    localparam logic [WAW-1:0] ADDR_LAST = {WAW{1'b1}};
    localparam logic [WAW-1:0] ADDR_ONE  = WAW'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_W0   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_R5   = 3'd4;
    localparam logic [2:0] S_TAIL = 3'd5;

    logic [2:0]     state_q,     state_d;
    logic [2:0]     elem_q,      elem_d;
    logic [WAW-1:0] addr_q,      addr_d;
    logic           cs_q,        cs_d;
    logic [3:0]     wren_q,      wren_d;
    logic [31:0]    wdata_q,     wdata_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;
    logic           fail_q,      fail_d;
    logic [WAW-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]     fail_elem_q, fail_elem_d;

    logic           cmp_en;
    logic [WAW-1:0] cmp_addr;
    logic [31:0]    exp_data;
    logic           down;
    logic [WAW-1:0] elem_end;

    // Next-state, next-output and compare logic
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        cs_d        = cs_q;
        wren_d      = wren_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        cmp_en      = 1'b0;
        cmp_addr    = addr_q;
        // odd elements read "0", even elements read "1"
        exp_data    = elem_q[0] ? DATA0 : ~DATA0;
        down        = (elem_q == 3'd3) || (elem_q == 3'd4);
        elem_end    = down ? ADDR_ZERO : ADDR_LAST;

        case (state_q)
            S_IDLE: begin
                cs_d   = 1'b0;
                wren_d = 4'h0;
                if (start) begin
                    state_d     = S_W0;
                    elem_d      = 3'd0;
                    addr_d      = ADDR_ZERO;
                    cs_d        = 1'b1;
                    wren_d      = 4'hF;
                    wdata_d     = DATA0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_addr_d = ADDR_ZERO;
                    fail_elem_d = 3'd0;
                end
            end
            S_W0: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = S_RD;
                    elem_d  = 3'd1;
                    addr_d  = ADDR_ZERO;
                    wren_d  = 4'h0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_RD: begin
                state_d = S_WR;
                wren_d  = 4'hF;
                wdata_d = elem_q[0] ? ~DATA0 : DATA0;
            end
            S_WR: begin
                cmp_en  = 1'b1;
                state_d = S_RD;
                wren_d  = 4'h0;
                if (addr_q == elem_end) begin
                    elem_d = elem_q + 3'd1;
                    if (elem_q == 3'd4) begin
                        state_d = S_R5;
                        addr_d  = ADDR_ZERO;
                    end else begin
                        addr_d = (elem_q == 3'd1) ? ADDR_ZERO : ADDR_LAST;
                    end
                end else begin
                    addr_d = down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
                end
            end
            S_R5: begin
                // pipelined: this cycle's RDATA belongs to the previous address
                cmp_en   = (addr_q != ADDR_ZERO);
                cmp_addr = addr_q - ADDR_ONE;
                if (addr_q == ADDR_LAST) begin
                    state_d = S_TAIL;
                    cs_d    = 1'b0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_TAIL: begin
                cmp_en  = 1'b1;
                state_d = S_IDLE;
                cs_d    = 1'b0;
                wren_d  = 4'h0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cs_d    = 1'b0;
                wren_d  = 4'h0;
                busy_d  = 1'b0;
            end
        endcase

        if (cmp_en && !fail_q && (sram.rdata != exp_data)) begin
            fail_d      = 1'b1;
            fail_addr_d = cmp_addr;
            fail_elem_d = elem_q;
        end
    end

    // State and output registers
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= ADDR_ZERO;
            cs_q        <= 1'b0;
            wren_q      <= 4'h0;
            wdata_q     <= 32'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= ADDR_ZERO;
            fail_elem_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            wren_q      <= wren_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    assign sram.cs    = cs_q;
    assign sram.addr  = addr_q;
    assign sram.wdata = wdata_q;
    assign sram.wren  = wren_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign fail_addr  = fail_addr_q;
    assign fail_elem  = fail_elem_q;

endmodule

// File: tb/tb_sl_sram_bist.sv
// Bench for sl_sram_bist: two instances (DATA0=0 with fault injection, DATA0=5555_5555) on SRAM models.
module tb_sl_sram_bist;
    localparam int unsigned AW = 6;
    localparam int DEPTH = 16;
    localparam int RUN_LEN = 10 * DEPTH + 1;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
    } acc_t;

    typedef struct packed {
        logic       fail;
        logic [3:0] faddr;
        logic [2:0] felem;
    } res_t;

    logic clk;
    logic hresetn;
    logic start0, start5;
    logic busy0, done0, fail0, busy5, done5, fail5;
    logic [3:0] fail_addr0, fail_addr5;
    logic [2:0] fail_elem0, fail_elem5;

    int n_assert = 0;
    int n_fail = 0;
    int completions = 0;
    int fault = 0;
    int busy_cnt = 0;
    logic prev_busy = 1'b0;

    logic [31:0] mem0 [DEPTH];
    logic [31:0] mem5 [DEPTH];
    acc_t q0[$];
    acc_t q5[$];
    res_t res_q[$];

    sl_sram_bist_if #(.AW(AW)) if0 ();
    sl_sram_bist_if #(.AW(AW)) if5 ();

    sl_sram_bist #(.AW(AW), .DATA0(32'h0000_0000)) dut0 (
        .hclk(clk), .hresetn(hresetn), .start(start0),
        .busy(busy0), .done(done0), .fail(fail0),
        .fail_addr(fail_addr0), .fail_elem(fail_elem0), .sram(if0)
    );

    sl_sram_bist #(.AW(AW), .DATA0(32'h5555_5555)) dut5 (
        .hclk(clk), .hresetn(hresetn), .start(start5),
        .busy(busy5), .done(done5), .fail(fail5),
        .fail_addr(fail_addr5), .fail_elem(fail_elem5), .sram(if5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM model for dut0 with optional stuck-at (word 9 bit 7) and coupling (word 3 1->0 flips word 2 bit 0)
    always @(posedge clk) begin
        logic [31:0] old, nw, rd;
        if (if0.cs) begin
            old = mem0[if0.addr];
            rd = old;
            if (fault == 1 && if0.addr == 4'd9) rd[7] = 1'b1;
            if0.rdata <= rd;
            if (if0.wren != 4'h0) begin
                nw = old;
                for (int b = 0; b < 4; b++)
                    if (if0.wren[b]) nw[8*b +: 8] = if0.wdata[8*b +: 8];
                mem0[if0.addr] = nw;
                if (fault == 2 && if0.addr == 4'd3 && old[0] === 1'b1 && nw[0] == 1'b0)
                    mem0[2][0] = ~mem0[2][0];
            end
        end
    end

    always @(posedge clk) begin
        logic [31:0] nw;
        if (if5.cs) begin
            if5.rdata <= mem5[if5.addr];
            if (if5.wren != 4'h0) begin
                nw = mem5[if5.addr];
                for (int b = 0; b < 4; b++)
                    if (if5.wren[b]) nw[8*b +: 8] = if5.wdata[8*b +: 8];
                mem5[if5.addr] = nw;
            end
        end
    end

    // Expected March C- access sequence for one run
    task automatic push_trace(input int which, input logic [31:0] d0);
        acc_t seq[$];
        logic [3:0] a;
        for (int i = 0; i < DEPTH; i++) seq.push_back('{1'b1, 4'(i), d0});
        for (int e = 1; e <= 4; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = (e <= 2) ? 4'(k) : 4'(DEPTH - 1 - k);
                seq.push_back('{1'b0, a, 32'h0});
                seq.push_back('{1'b1, a, (e % 2 == 1) ? ~d0 : d0});
            end
        end
        for (int i = 0; i < DEPTH; i++) seq.push_back('{1'b0, 4'(i), 32'h0});
        foreach (seq[i]) begin
            if (which == 0) q0.push_back(seq[i]);
            else q5.push_back(seq[i]);
        end
    endtask

    // Bus monitors and end-of-run scoreboard
    always @(negedge clk) begin
        acc_t e;
        res_t r;
        if (if0.cs) begin
            n_assert++;
            assert (q0.size() != 0) else begin
                n_fail++;
                $error("FAIL trace0_extra: observed access at addr %0h, expected none", if0.addr);
            end
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("trace0", 64'({if0.wren, if0.addr, (if0.wren != 4'h0) ? if0.wdata : 32'h0}),
                    64'({e.we ? 4'hF : 4'h0, e.addr, e.we ? e.data : 32'h0}));
            end
        end
        if (if5.cs) begin
            n_assert++;
            assert (q5.size() != 0) else begin
                n_fail++;
                $error("FAIL trace5_extra: observed access at addr %0h, expected none", if5.addr);
            end
            if (q5.size() != 0) begin
                e = q5.pop_front();
                chk("trace5", 64'({if5.wren, if5.addr, (if5.wren != 4'h0) ? if5.wdata : 32'h0}),
                    64'({e.we ? 4'hF : 4'h0, e.addr, e.we ? e.data : 32'h0}));
            end
        end
        if (busy0 && !prev_busy) busy_cnt = 1;
        else if (busy0) busy_cnt++;
        if (!busy0 && prev_busy && done0) begin
            if (res_q.size() != 0) begin
                r = res_q.pop_front();
                chk("busy_len", 64'(busy_cnt), 64'(RUN_LEN));
                chk("fail", 64'(fail0), 64'(r.fail));
                chk("fail_addr", 64'(fail_addr0), 64'(r.faddr));
                chk("fail_elem", 64'(fail_elem0), 64'(r.felem));
                chk("trace0_left", 64'(q0.size()), 64'(0));
            end
            completions++;
        end
        prev_busy = busy0;
    end

    task automatic launch(input logic ef, input logic [3:0] fa, input logic [2:0] fe);
        res_q.push_back('{ef, fa, fe});
        push_trace(0, 32'h0);
        start0 = 1'b1;
    endtask

    task automatic wait_done(input int target, input bit hold);
        for (int i = 0; i < 400 && completions < target; i++) begin
            @(negedge clk);
            if (!hold || !busy0) start0 = 1'b0;
        end
        start0 = 1'b0;
        chk("run_complete", 64'(completions), 64'(target));
    endtask

    initial begin
        hresetn = 1'b0;
        start0 = 1'b0;
        start5 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = 32'h0;
            mem5[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("rst_cs", 64'(if0.cs), 64'(0));
        chk("rst_wren", 64'(if0.wren), 64'(0));
        chk("rst_addr", 64'(if0.addr), 64'(0));
        chk("rst_wdata", 64'(if0.wdata), 64'(0));
        chk("rst_status", 64'({busy0, done0, fail0, fail_addr0, fail_elem0}), 64'(0));
        chk("rst_dut5", 64'({if5.cs, if5.wren, if5.wdata, busy5, done5, fail5}), 64'(0));
        hresetn = 1'b1;
        @(negedge clk);

        // Fault-free runs on both instances
        launch(1'b0, 4'd0, 3'd0);
        push_trace(5, 32'h5555_5555);
        start5 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start5 = 1'b0;
        chk("first_access", 64'({busy0, done0, if0.cs, if0.wren, if0.addr, if0.wdata}),
            64'({1'b1, 1'b0, 1'b1, 4'hF, 4'h0, 32'h0}));
        chk("first_wdata5", 64'(if5.wdata), 64'(32'h5555_5555));
        wait_done(1, 1'b0);
        chk("done0", 64'(done0), 64'(1));
        chk("idle_bus0", 64'({busy0, if0.cs, if0.wren}), 64'(0));
        chk("dut5_status", 64'({busy5, done5, fail5}), 64'({1'b0, 1'b1, 1'b0}));
        chk("trace5_left", 64'(q5.size()), 64'(0));

        // Stuck-at-1 bit 7 at word 9, START held through the run
        fault = 1;
        launch(1'b1, 4'd9, 3'd1);
        wait_done(2, 1'b1);
        chk("stuck_done_fail", 64'({done0, fail0}), 64'({1'b1, 1'b1}));

        // Re-pulse clears sticky DONE/FAIL on accept
        fault = 0;
        launch(1'b0, 4'd0, 3'd0);
        @(negedge clk);
        start0 = 1'b0;
        chk("accept_clears", 64'({busy0, done0, fail0}), 64'({1'b1, 1'b0, 1'b0}));
        wait_done(3, 1'b0);

        // Coupling fault: first detected going down in element 3
        fault = 2;
        launch(1'b1, 4'd2, 3'd3);
        wait_done(4, 1'b0);
        fault = 0;

        // Reset mid-run aborts without DONE
        push_trace(0, 32'h0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (49) @(negedge clk);
        chk("abort_pre_busy", 64'(busy0), 64'(1));
        hresetn = 1'b0;
        @(negedge clk);
        chk("abort_state", 64'({if0.cs, if0.wren, busy0, done0, fail0}), 64'(0));
        hresetn = 1'b1;
        q0.delete();

        // Full run after abort
        launch(1'b0, 4'd0, 3'd0);
        wait_done(5, 1'b0);
        chk("rerun_done", 64'({done0, fail0}), 64'({1'b1, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
